// File: rtl/apb_slv_mem_responder.sv
// APB3 slave responder over a small word-addressed register memory.
// Supports programmable wait states per transfer, error responses for
// out-of-range or misaligned addresses, and saturating transfer/error counters.
module apb_slv_mem_responder #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  wait_cfg,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic [15:0] xfer_cnt,
  output logic [7:0]  err_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Transfer fields captured in the setup cycle; the bus may change afterwards.
  logic          r_wr;
  logic          r_err;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_cnt;

  logic          r_pready;
  logic [31:0]   r_prdata;
  logic          r_pslverr;
  logic [15:0]   r_xfer_cnt;
  logic [7:0]    r_err_cnt;

  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_off;
  logic          w_err_in;
  logic [AW-1:0] w_idx_in;
  logic          w_setup;
  logic          w_complete;
  logic          w_commit;
  logic [3:0]    w_cnt_next;
  logic          w_pready_next;
  logic [31:0]   w_prdata_next;
  logic          w_pslverr_next;

  // Address decode on the live bus. Subtracting the base first keeps the range
  // test correct even when the window ends exactly at the top of the address map.
  assign w_off    = paddr - BASE_ADDR;
  assign w_err_in = (w_off >= 32'(4 * DEPTH)) || (paddr[1:0] != 2'b00);
  assign w_idx_in = w_off[AW+1:2];

  assign w_setup    = (r_state == S_IDLE) && psel && !penable;
  assign w_complete = (r_state == S_ACCESS) && psel && r_pready && penable;
  assign w_commit   = w_complete && r_wr && !r_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: setup enters ACCESS; completion or abort returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_setup) w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (!psel)                     w_state_next = S_IDLE;
        else if (r_pready && penable)  w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: wait countdown and the response loaded on the edge that raises pready.
  always_comb begin
    w_cnt_next     = r_cnt;
    w_pready_next  = 1'b0;
    w_prdata_next  = 32'h0;
    w_pslverr_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_cnt_next = wait_cfg;
          if (wait_cfg == 4'd0) begin
            w_pready_next  = 1'b1;
            w_pslverr_next = w_err_in;
            w_prdata_next  = (!pwrite && !w_err_in) ? r_mem[w_idx_in] : 32'h0;
          end
        end
      end
      S_ACCESS: begin
        if (psel) begin
          if (!r_pready) begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              w_pready_next  = 1'b1;
              w_pslverr_next = r_err;
              w_prdata_next  = (!r_wr && !r_err) ? r_mem[r_idx] : 32'h0;
            end
          end else if (!penable) begin
            // Ready already offered; hold the response until the master strobes penable.
            w_pready_next  = r_pready;
            w_prdata_next  = r_prdata;
            w_pslverr_next = r_pslverr;
          end
        end
      end
      default: begin
        w_cnt_next = 4'd0;
      end
    endcase
  end

  // Capture transfer fields in the setup cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
    end else if (w_setup) begin
      r_wr    <= pwrite;
      r_err   <= w_err_in;
      r_idx   <= w_idx_in;
      r_wdata <= pwdata;
    end
  end

  // Registered response and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_pready  <= 1'b0;
      r_prdata  <= 32'h0;
      r_pslverr <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_pready  <= w_pready_next;
      r_prdata  <= w_prdata_next;
      r_pslverr <= w_pslverr_next;
    end
  end

  // Saturating counters advance only on a completion edge, never on an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= 16'h0;
      r_err_cnt  <= 8'h0;
    end else if (w_complete) begin
      if (r_xfer_cnt != 16'hFFFF) r_xfer_cnt <= r_xfer_cnt + 16'd1;
      if (r_pslverr && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Register memory: cleared by reset, written only at a clean write completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
    end else if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign pready   = r_pready;
  assign prdata   = r_prdata;
  assign pslverr  = r_pslverr;
  assign xfer_cnt = r_xfer_cnt;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_apb_slv_mem_responder.sv
// Directed bench for apb_slv_mem_responder (DEPTH=16, BASE_ADDR=0).
module tb_apb_slv_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  wait_cfg;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [15:0] xfer_cnt;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int exp_xfer = 0;
  int exp_err  = 0;

  always #5 clk = ~clk;

  apb_slv_mem_responder #(
    .DEPTH     (16),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .wait_cfg (wait_cfg),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr),
    .xfer_cnt (xfer_cnt),
    .err_cnt  (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transfer starting right now (no idle cycle before it). Bus fields are
  // scrambled after setup so only the captured values can produce the right result.
  task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] ws,
                          input logic [31:0] exp_rd, input logic exp_e);
    int lat;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; wait_cfg = ws;
    @(posedge clk); #1;
    penable = 1'b1; paddr = ~addr; pwdata = ~wdata; wait_cfg = ~ws;
    lat = 1;
    while (pready !== 1'b1 && lat <= 20) begin
      chk({tag, "_wait_prdata"}, prdata, 32'h0);
      chk({tag, "_wait_pslverr"}, {31'h0, pslverr}, 32'h0);
      @(posedge clk); #1;
      lat++;
    end
    if (lat > 20) chk({tag, "_timeout"}, {31'h0, pready}, 32'h1);
    chk({tag, "_latency"}, lat, 32'(ws) + 32'd1);
    chk({tag, "_pslverr"}, {31'h0, pslverr}, {31'h0, exp_e});
    if (!wr) chk({tag, "_prdata"}, prdata, exp_rd);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    exp_xfer = (exp_xfer == 65535) ? 65535 : exp_xfer + 1;
    if (exp_e) exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    chk({tag, "_post_pready"}, {31'h0, pready}, 32'h0);
    chk({tag, "_post_prdata"}, prdata, 32'h0);
    chk({tag, "_xfer_cnt"}, {16'h0, xfer_cnt}, 32'(exp_xfer));
    chk({tag, "_err_cnt"}, {24'h0, err_cnt}, 32'(exp_err));
    $display("xfer %s wr=%0b addr=0x%08h ws=%0d lat=%0d prdata=0x%08h pslverr=%0b",
             tag, wr, addr, ws, lat, exp_rd, exp_e);
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; wait_cfg = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", {31'h0, pready}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_xfer_cnt", {16'h0, xfer_cnt}, 32'h0);
    chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Penable without setup is ignored.
    penable = 1'b1;
    @(posedge clk); #1;
    chk("stray_penable_pready", {31'h0, pready}, 32'h0);
    idle(1);

    // Zero-wait write then read.
    apb_xfer("w08", 1'b1, 32'h08, 32'hDEAD_BEEF, 4'd0, 32'h0, 1'b0);
    apb_xfer("r08", 1'b0, 32'h08, 32'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);
    idle(1);

    // Three wait states on a reset-valued word.
    apb_xfer("r04_ws3", 1'b0, 32'h04, 32'h0, 4'd3, 32'h0, 1'b0);
    idle(1);

    // Out-of-range and misaligned accesses.
    apb_xfer("w40_oor", 1'b1, 32'h40, 32'h1234_5678, 4'd0, 32'h0, 1'b1);
    apb_xfer("w06_mis", 1'b1, 32'h06, 32'h1234_5678, 4'd0, 32'h0, 1'b1);
    apb_xfer("r40_oor", 1'b0, 32'h40, 32'h0, 4'd0, 32'h0, 1'b1);
    apb_xfer("r00_chk", 1'b0, 32'h00, 32'h0, 4'd0, 32'h0, 1'b0);
    apb_xfer("r04_chk", 1'b0, 32'h04, 32'h0, 4'd2, 32'h0, 1'b0);
    idle(1);

    // Master abort during wait states.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hCAFE_F00D; wait_cfg = 4'd5;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) begin
      chk("abort_wait_pready", {31'h0, pready}, 32'h0);
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("abort_pready", {31'h0, pready}, 32'h0);
    chk("abort_xfer_cnt", {16'h0, xfer_cnt}, 32'(exp_xfer));
    $display("xfer abort addr=0x0000000c ws=5 dropped after 2 access cycles");
    apb_xfer("r0c_after_abort", 1'b0, 32'h0C, 32'h0, 4'd0, 32'h0, 1'b0);
    idle(1);

    // Back-to-back zero-wait writes, then read both back.
    apb_xfer("b2b_w00", 1'b1, 32'h00, 32'h1111_1111, 4'd0, 32'h0, 1'b0);
    apb_xfer("b2b_w04", 1'b1, 32'h04, 32'h2222_2222, 4'd0, 32'h0, 1'b0);
    apb_xfer("b2b_r00", 1'b0, 32'h00, 32'h0, 4'd0, 32'h1111_1111, 1'b0);
    apb_xfer("b2b_r04", 1'b0, 32'h04, 32'h0, 4'd1, 32'h2222_2222, 1'b0);
    idle(1);

    // Drive the error counter to saturation.
    for (int i = 0; i < 260; i++) begin
      apb_xfer("sat", 1'b0, 32'h40, 32'h0, 4'd0, 32'h0, 1'b1);
    end
    chk("err_cnt_saturated", {24'h0, err_cnt}, 32'h0000_00FF);
    idle(1);

    // Reset asserted in the 2nd wait cycle of a write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hA5A5_A5A5; wait_cfg = 4'd3;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_xfer = 0; exp_err = 0;
    chk("midrst_pready", {31'h0, pready}, 32'h0);
    chk("midrst_xfer_cnt", {16'h0, xfer_cnt}, 32'h0);
    chk("midrst_err_cnt", {24'h0, err_cnt}, 32'h0);
    $display("xfer reset during write addr=0x00000010");
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    apb_xfer("r10_after_rst", 1'b0, 32'h10, 32'h0, 4'd0, 32'h0, 1'b0);
    apb_xfer("r00_after_rst", 1'b0, 32'h00, 32'h0, 4'd0, 32'h0, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
